axi4_wr_slave: RTL

Memory-backed AXI4 write-channel responder: the slave end of the write path. It accepts one AW burst descriptor, absorbs the W data beats into an internal word memory and returns a single B response. It sits behind the interconnect's register slices as the write target for fabric verification. It processes one burst at a time with no write interleaving.

---
 rtl/axi4_wr_slave.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/axi4_wr_slave.sv
// Memory-backed AXI4 write responder: one AW burst, W beats into a word memory, one B response.
// Optional byte-strobe masking is enabled by defining AXI4_WR_SLAVE_WSTRB_EN.
module axi4_wr_slave #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [ID_W-1:0]              awid,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wlast,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [ID_W-1:0]              bid,
  output logic [1:0]                   bresp,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]            dbg_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int WI_W   = ADDR_W - LSB;
  localparam int MI_W   = $clog2(MEM_DEPTH);
  localparam logic [WI_W:0] DEPTH_L = (WI_W + 1)'(MEM_DEPTH);
  localparam logic [WI_W:0] ONE_L   = (WI_W + 1)'(1);

  typedef enum logic [1:0] {BOOT, IDLE, DATA, RESP} state_t;

  state_t              state, state_nx;
  logic [ID_W-1:0]     id_q;
  logic [WI_W:0]       widx;
  logic [7:0]          len_q;
  logic [7:0]          beat_cnt;
  logic                fixed_q;
  logic                aw_err;
  logic                dec_err;
  logic                wl_err;
  logic                aw_hs;
  logic                w_hs;
  logic                last_beat;
  logic                in_range;
  logic                mem_we;
  logic [MI_W-1:0]     mem_idx;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];
  logic                unused_bits;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign last_beat = (beat_cnt == len_q);
  // Index carries one extra bit so INCR bursts running past the top stay out of range.
  assign in_range  = (widx < DEPTH_L);
  assign mem_we    = w_hs && !aw_err && in_range;
  assign mem_idx   = widx[MI_W-1:0];
  assign bid       = id_q;
  assign dbg_rdata = mem[dbg_addr];
  assign unused_bits = ^{awaddr, wstrb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    case (state)
      BOOT: state_nx = IDLE;
      IDLE: begin
        awready = 1'b1;
        if (awvalid) state_nx = DATA;
      end
      DATA: begin
        wready = 1'b1;
        if (wvalid && last_beat) state_nx = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        if (bready) state_nx = IDLE;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_comb begin
    bresp = '0;
    if (state == RESP) begin
      if (dec_err)               bresp = 2'b11;
      else if (aw_err || wl_err) bresp = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= '0;
      widx     <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      fixed_q  <= 1'b0;
      aw_err   <= 1'b0;
      dec_err  <= 1'b0;
      wl_err   <= 1'b0;
    end else if (aw_hs) begin
      id_q     <= awid;
      widx     <= {1'b0, awaddr[ADDR_W-1:LSB]};
      len_q    <= awlen;
      beat_cnt <= '0;
      fixed_q  <= (awburst == 2'b00);
      aw_err   <= awburst[1] || (awsize != 3'(LSB));
      dec_err  <= 1'b0;
      wl_err   <= 1'b0;
    end else if (w_hs) begin
      beat_cnt <= beat_cnt + 8'd1;
      if (!fixed_q)             widx    <= widx + ONE_L;
      if (!aw_err && !in_range) dec_err <= 1'b1;
      if (wlast != last_beat)   wl_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef AXI4_WR_SLAVE_WSTRB_EN
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[mem_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
`else
      mem[mem_idx] <= wdata;
`endif
    end
  end

endmodule
